// File: rtl/text_pkg.sv
// Shared timing and text-box constants for the text scan generator.
package text_pkg;

  // Default 800x600 timing, horizontal in clocks, vertical in lines.
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Text box row: N_BOX boxes side by side starting at (X_BOX, Y_BOX).
  localparam int X_BOX_DEF = 88;
  localparam int Y_BOX_DEF = 32;
  localparam int BOX_W_DEF = 50;
  localparam int BOX_H_DEF = 40;
  localparam int N_BOX_DEF = 8;
  localparam int N_BOX_MAX = 8;

  typedef logic [8:0] glyph_addr_t;

  localparam glyph_addr_t BLANK_ADDR_DEF = 9'h000;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with registered sync, active-video,
// frame-start and vertical-blank flags. The next-pixel coordinates are
// exported so the parent can register its own per-pixel outputs in step.
module vga_timing
  import text_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        vblank,
  output logic [10:0] next_x,
  output logic [9:0]  next_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;

  // Next scan position: x wraps every line, y steps only on the x wrap.
  always_comb begin
    h_wrap = (pixel_x == H_LAST);
    next_x = h_wrap ? 11'd0 : pixel_x + 11'd1;
    next_y = pixel_y;
    if (h_wrap) next_y = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
  end

  // Counters and flags all load from the next position so they stay aligned.
  // Reset parks the scan on pixel (0,0), which is a frame start in active video.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      video_on    <= 1'b1;
      frame_start <= 1'b1;
      vblank      <= 1'b0;
    end else begin
      pixel_x     <= next_x;
      pixel_y     <= next_y;
      hsync       <= (next_x >= HS_ON) && (next_x < HS_OFF);
      vsync       <= (next_y >= VS_ON) && (next_y < VS_OFF);
      video_on    <= (next_x < H_ACT) && (next_y < V_ACT);
      frame_start <= (next_x == 11'd0) && (next_y == 10'd0);
      vblank      <= (next_y >= V_ACT);
    end
  end

endmodule

// File: rtl/text_scan_gen.sv
// Text-box scan generator: VGA timing plus a row of character boxes whose
// glyph ROM base addresses come from a small host-written buffer. Host
// writes are only taken during vertical blanking so a frame never tears.
module text_scan_gen
  import text_pkg::*;
#(
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          H_FP       = H_FP_DEF,
  parameter int          H_SYNC     = H_SYNC_DEF,
  parameter int          H_BP       = H_BP_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter int          V_FP       = V_FP_DEF,
  parameter int          V_SYNC     = V_SYNC_DEF,
  parameter int          V_BP       = V_BP_DEF,
  parameter int          X_BOX      = X_BOX_DEF,
  parameter int          Y_BOX      = Y_BOX_DEF,
  parameter int          BOX_W      = BOX_W_DEF,
  parameter int          BOX_H      = BOX_H_DEF,
  parameter int          N_BOX      = N_BOX_DEF,
  parameter logic [8:0]  BLANK_ADDR = BLANK_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_idx,
  input  logic [8:0]  wr_addr,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic [8:0]  rom_base_addr,
  output logic        in_box
);

  localparam logic [11:0] X_LO = 12'(X_BOX);
  localparam logic [11:0] X_HI = 12'(X_BOX + N_BOX * BOX_W);
  localparam logic [10:0] Y_LO = 11'(Y_BOX);
  localparam logic [10:0] Y_HI = 11'(Y_BOX + BOX_H);

  logic [10:0] next_x;
  logic [9:0]  next_y;
  logic [11:0] nx_w;
  logic [10:0] ny_w;

  glyph_addr_t [N_BOX_MAX-1:0] char_buf;

  logic        wr_take, wr_keep;
  logic        box_hit;
  logic [2:0]  box_idx;
  glyph_addr_t box_glyph;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start),
    .vblank      (wr_ready),
    .next_x      (next_x),
    .next_y      (next_y)
  );

  // Accept any offered write in blanking; out-of-range indices are dropped.
  always_comb begin
    wr_take = wr_valid && wr_ready;
    wr_keep = wr_take && ({1'b0, wr_idx} < 4'(N_BOX));
  end

  // Box lookup on the next pixel via a compare chain against the fixed
  // box boundaries. A write landing on this edge is forwarded so the glyph
  // shown never lags the buffer.
  always_comb begin
    nx_w    = {1'b0, next_x};
    ny_w    = {1'b0, next_y};
    box_hit = (nx_w >= X_LO) && (nx_w < X_HI) && (ny_w >= Y_LO) && (ny_w < Y_HI);
    box_idx = '0;
    for (int i = 1; i < N_BOX; i++)
      if (nx_w >= 12'(X_BOX + i * BOX_W)) box_idx = 3'(i);
    box_glyph = (wr_keep && (wr_idx == box_idx)) ? wr_addr : char_buf[box_idx];
  end

  // Character buffer; reset blanks every entry and wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst)          char_buf <= {N_BOX_MAX{BLANK_ADDR}};
    else if (wr_keep) char_buf[wr_idx] <= wr_addr;
  end

  // Registered box outputs, aligned with the timing sub-module's registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_box        <= 1'b0;
      rom_base_addr <= BLANK_ADDR;
    end else begin
      in_box        <= box_hit;
      rom_base_addr <= box_hit ? box_glyph : BLANK_ADDR;
    end
  end

endmodule

// File: doc/text_scan_gen.md
TEXT_SCAN_GEN -- requirements
Module: text_scan_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 40, 128, 88, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 600, 1, 4, 23, vertical lines.
REQ-004 SHALL have parameters X_BOX, Y_BOX, BOX_W, BOX_H, N_BOX, defaults 88, 32, 50, 40, 8: first box corner, box size, box count (N_BOX at most 8).
REQ-005 SHALL have parameter BLANK_ADDR, default 9'h000, ROM base address of the blank glyph.
REQ-006 clk  input  1  pixel clock; all logic on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 wr_valid  input  1  host offers a character-buffer write.
REQ-009 wr_ready  output  1  block accepts the write this cycle.
REQ-010 wr_idx  input  3  box index to update.
REQ-011 wr_addr  input  9  glyph ROM base address for that box.
REQ-012 pixel_x  output  11  current horizontal count.
REQ-013 pixel_y  output  10  current vertical count.
REQ-014 hsync, vsync  output  1 each  sync pulses, active-high.
REQ-015 video_on  output  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-016 frame_start  output  1  one-cycle pulse when pixel_x=0 and pixel_y=0.
REQ-017 rom_base_addr  output  9  glyph base address for the box containing (pixel_x, pixel_y).
REQ-018 in_box  output  1  high when (pixel_x, pixel_y) lies inside any box.

Function
REQ-019 pixel_x SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056 by default).
REQ-020 pixel_y SHALL increment only on the pixel_x wrap and SHALL wrap from V_TOTAL-1 to 0, where V_TOTAL = 628 by default.
REQ-021 hsync SHALL be high for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), which is [840, 968) by default.
REQ-022 vsync SHALL be high for pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), which is [601, 605) by default.
REQ-023 Box i SHALL cover x in [X_BOX+i*BOX_W, X_BOX+(i+1)*BOX_W) and y in [Y_BOX, Y_BOX+BOX_H), with both edges half-open.
REQ-024 Inside box i, rom_base_addr SHALL equal buffer entry i and in_box SHALL be 1; outside every box, rom_base_addr SHALL be BLANK_ADDR and in_box SHALL be 0.
REQ-025 Every output SHALL be registered and SHALL describe the same pixel in the same cycle, with zero relative skew.
REQ-026 Box lookup SHALL use a running box counter or compare chain; dividers are not permitted.
REQ-027 wr_ready SHALL be 1 exactly when pixel_y >= V_ACTIVE (vertical blanking), so the buffer never changes during active video.
REQ-028 A write SHALL be accepted on a cycle where wr_valid and wr_ready are both 1; the entry SHALL update on that edge.
REQ-029 If wr_valid is 1 while wr_ready is 0, the host SHALL hold wr_idx and wr_addr stable; the write SHALL complete on the first blanking cycle.
REQ-030 An accepted write with wr_idx >= N_BOX SHALL be acknowledged and discarded.
REQ-031 A write accepted on the last blanking line SHALL be visible from the next frame's first active line.

Reset
REQ-032 While rst is high, pixel_x, pixel_y, hsync, vsync and in_box SHALL be 0, rom_base_addr SHALL be BLANK_ADDR, and every buffer entry SHALL be BLANK_ADDR.
REQ-033 On the cycle after rst is deasserted, the outputs SHALL show pixel (0,0), frame_start SHALL be 1 and video_on SHALL be 1.
REQ-034 rst asserted mid-frame SHALL restart the scan at (0,0) and SHALL abandon any pending write, with no partial update.

Structure
REQ-035 The default timing constants, H_TOTAL/V_TOTAL, the box geometry and BLANK_ADDR SHALL live in the shared package text_pkg.
REQ-036 The h/v counters and sync generation SHALL form one sub-module, vga_timing; box lookup and the character buffer SHALL live in text_scan_gen.

Verification
REQ-037 Release rst, run 1056*628 clocks -> exactly one frame_start, 628 hsync pulses each 128 clocks wide, one vsync pulse 4 lines wide.
REQ-038 With entry 0 = 9'h028, pixel (88,32) -> in_box=1 and rom_base_addr=9'h028; pixel (87,32) and pixel (88,72) -> in_box=0 and rom_base_addr=BLANK_ADDR.
REQ-039 Box edge: pixel (137,50) -> entry 0; pixel (138,50) -> entry 1; pixel (488,50) -> in_box=0.
REQ-040 Assert wr_valid with wr_idx=3, wr_addr=9'h030 at pixel_y=10 -> wr_ready stays 0 until pixel_y=600, the write completes there, and box 3 shows 9'h030 in the next frame only.
REQ-041 Write wr_idx=7 with N_BOX=6 -> accepted; boxes 0-5 unchanged.
REQ-042 Assert rst at pixel (500,300) -> the next cycle shows (0,0), all entries read back BLANK_ADDR, and the pending write is dropped.
